// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU package: arbiter state encoding and datapath widths.
package cpu_pkg;

   // Address/data widths shared with the cpu datapath.
   localparam int CPU_AW = 32;
   localparam int CPU_DW = 32;

   // Memory port arbiter states.
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;

endpackage : cpu_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory bus seen by the arbiter.
//
// Handshake semantics:
//   cpu side : if_req/d_req are levels held until the matching x_valid pulse
//              (if_req may also drop on if_flush). x_valid is a single-cycle pulse
//              and x_rdata is valid in that cycle. x_stall = x_req & ~x_valid.
//   mem side : mem_req and all mem_* stay stable from the grant edge until the
//              edge on which mem_ready=1 is sampled; mem_ready is ignored while
//              mem_req=0.
interface mem_port_arbiter_if
   import cpu_pkg::*;
#(
   parameter int AW = CPU_AW,
   parameter int DW = CPU_DW
);
   // Fetch port
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          if_stall;
   // Data port
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_valid;
   logic          d_stall;
   // Memory bus
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   // Arbiter view.
   modport slave (
      input  if_req, if_addr, if_flush,
      input  d_req, d_we, d_addr, d_wdata,
      input  mem_rdata, mem_ready,
      output if_rdata, if_valid, if_stall,
      output d_rdata, d_valid, d_stall,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   // Pipeline plus memory view.
   modport master (
      output if_req, if_addr, if_flush,
      output d_req, d_we, d_addr, d_wdata,
      output mem_rdata, mem_ready,
      input  if_rdata, if_valid, if_stall,
      input  d_rdata, d_valid, d_stall,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter_prio.sv
// Grant select for the shared memory port: data has fixed priority unless the
// fetch port has been passed over STARVE_MAX times in a row.
module mem_arb_prio
   import cpu_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               idle,
   input  logic                               if_req,
   input  logic                               if_flush,
   input  logic                               d_req,
   output logic                               grant_d,
   output logic                               grant_i,
   output logic [$clog2(STARVE_MAX+1)-1:0]    starve_cnt
);

   localparam int            CW      = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic guard_full;

   // Grant decision, only meaningful while the port is idle; a flush blocks
   // the fetch grant for that cycle only.
   always_comb begin
      guard_full = if_req & (starve_cnt == CNT_MAX);
      grant_d    = idle & d_req & ~guard_full;
      grant_i    = idle & ~grant_d & if_req & ~if_flush;
   end

   // Saturating count of data grants taken while a fetch was waiting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!if_req || grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end

endmodule : mem_arb_prio

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and load/store. Sequences one access at a time, returns read data to the
// winner and drives the pipeline stall terms.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int AW         = CPU_AW,
   parameter int DW         = CPU_DW,
   parameter int STARVE_MAX = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   mem_port_arbiter_if.slave                bus,
   output logic [1:0]                       dbg_state,
   output logic [$clog2(STARVE_MAX+1)-1:0]  dbg_starve_cnt
);

   arb_state_t    state_q, state_d;
   logic          idle;
   logic          grant_d, grant_i;
   logic          mem_done;
   logic          flush_pend_q;

   logic          mem_req_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [DW-1:0] if_rdata_q;
   logic [DW-1:0] d_rdata_q;
   logic          if_valid_q;
   logic          d_valid_q;

   assign idle     = (state_q == ARB_IDLE);
   // mem_ready only counts while a request is actually outstanding.
   assign mem_done = mem_req_q & bus.mem_ready;

   mem_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk        (clk),
      .rst        (rst),
      .idle       (idle),
      .if_req     (bus.if_req),
      .if_flush   (bus.if_flush),
      .d_req      (bus.d_req),
      .grant_d    (grant_d),
      .grant_i    (grant_i),
      .starve_cnt (dbg_starve_cnt)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: idle -> busy on a grant, busy -> idle when memory completes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_d) begin
               state_d = ARB_BUSY_D;
            end else if (grant_i) begin
               state_d = ARB_BUSY_I;
            end
         end
         ARB_BUSY_I, ARB_BUSY_D: begin
            if (mem_done) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Memory request registers: loaded on the grant edge, held until completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else if (grant_d) begin
         mem_req_q   <= 1'b1;
         mem_we_q    <= bus.d_we;
         mem_addr_q  <= bus.d_addr;
         mem_wdata_q <= bus.d_wdata;
      end else if (grant_i) begin
         mem_req_q   <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= bus.if_addr;
         mem_wdata_q <= '0;
      end else if (mem_done) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
      end
   end

   // A redirect during a fetch marks its result as stale; cleared at completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_pend_q <= 1'b0;
      end else if ((state_q == ARB_BUSY_I) && !mem_done) begin
         if (bus.if_flush) begin
            flush_pend_q <= 1'b1;
         end
      end else begin
         flush_pend_q <= 1'b0;
      end
   end

   // Return path: capture read data and pulse the winner's valid for one cycle.
   // A flush arriving in the completion cycle itself also discards the fetch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if (mem_done && (state_q == ARB_BUSY_I)) begin
            if (!(flush_pend_q || bus.if_flush)) begin
               if_valid_q <= 1'b1;
               if_rdata_q <= bus.mem_rdata;
            end
         end else if (mem_done && (state_q == ARB_BUSY_D)) begin
            d_valid_q <= 1'b1;
            if (!mem_we_q) begin
               d_rdata_q <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.if_stall  = bus.if_req & ~if_valid_q;
   assign bus.d_stall   = bus.d_req & ~d_valid_q;
   assign dbg_state     = state_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model with programmable latency,
// cpu-side drivers, and a scoreboard of expected grants and returned data.
module tb_mem_port_arbiter;
   import cpu_pkg::*;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  cnt;
   } mem_exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
   logic [1:0] dbg_state;
   logic [2:0] dbg_starve_cnt;

   mem_port_arbiter #(
      .AW         (32),
      .DW         (32),
      .STARVE_MAX (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .dbg_state      (dbg_state),
      .dbg_starve_cnt (dbg_starve_cnt)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   int if_seen = 0;
   int d_seen  = 0;
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_d_q[$];
   mem_exp_t    exp_mem_q[$];

   logic [31:0] mem [logic [31:0]];
   int          mem_lat = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got=timeout exp=event", name);
   endtask

   task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] cnt);
      exp_mem_q.push_back('{we: we, addr: addr, wdata: wdata, cnt: cnt});
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   // ---------------- memory model + request checker ----------------
   initial begin : mem_model
      mem_exp_t cur;
      logic     active;
      int       wait_cnt;
      active   = 1'b0;
      wait_cnt = 0;
      cur      = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ready = 1'b0;
         if (!rst || !bus.mem_req) begin
            active   = 1'b0;
            wait_cnt = 0;
         end else begin
            if (!active) begin
               active   = 1'b1;
               wait_cnt = 0;
               if (exp_mem_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL mem_unexpected: got addr=%0h exp none", bus.mem_addr);
                  cur = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata, cnt: dbg_starve_cnt};
               end else begin
                  cur = exp_mem_q.pop_front();
                  check("grant_starve_cnt", dbg_starve_cnt, cur.cnt);
               end
            end
            check("mem_we", bus.mem_we, cur.we);
            check("mem_addr", bus.mem_addr, cur.addr);
            check("mem_wdata", bus.mem_wdata, cur.wdata);
            if (wait_cnt == mem_lat) begin
               bus.mem_ready = 1'b1;
               if (bus.mem_we) begin
                  mem[bus.mem_addr] = bus.mem_wdata;
                  bus.mem_rdata = 32'h5A5A5A5A;
               end else begin
                  bus.mem_rdata = mem_rd(bus.mem_addr);
               end
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst) begin
         if (bus.if_valid) begin
            if_seen++;
            if (exp_if_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL if_valid_unexpected: got rdata=%0h exp none", bus.if_rdata);
            end else begin
               e = exp_if_q.pop_front();
               check("if_rdata", bus.if_rdata, e);
            end
            check("if_stall_with_valid", bus.if_stall, 1'b0);
         end
         if (bus.d_valid) begin
            d_seen++;
            if (exp_d_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL d_valid_unexpected: got rdata=%0h exp none", bus.d_rdata);
            end else begin
               e = exp_d_q.pop_front();
               check("d_rdata", bus.d_rdata, e);
            end
            check("d_stall_with_valid", bus.d_stall, 1'b0);
         end
      end
   end

   // ---------------- driver tasks (entered at negedge + 1) ----------------
   task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string name);
      int base;
      int n;
      base = d_seen;
      n    = 0;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_req   = 1'b1;
      while (d_seen == base && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (d_seen == base) fail_now(name);
      bus.d_req = 1'b0;
   endtask

   task automatic run_i(input logic [31:0] addr, input string name);
      int base;
      int n;
      base = if_seen;
      n    = 0;
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
      while (if_seen == base && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (if_seen == base) fail_now(name);
      bus.if_req = 1'b0;
   endtask

   task automatic wait_mem_req(input logic level, input string name);
      int n;
      n = 0;
      while (bus.mem_req !== level && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (bus.mem_req !== level) fail_now(name);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #300000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int base_d;
      int base_i;
      int n;
      bus.if_req   = 1'b0;
      bus.if_addr  = 32'h0;
      bus.if_flush = 1'b0;
      bus.d_req    = 1'b0;
      bus.d_we     = 1'b0;
      bus.d_addr   = 32'h0;
      bus.d_wdata  = 32'h0;
      mem[32'h40]  = 32'h8C010004;
      mem[32'h44]  = 32'h11111111;
      mem[32'h48]  = 32'h00430820;
      mem[32'h80]  = 32'h20020080;
      mem[32'h100] = 32'hA5A50100;
      mem[32'h300] = 32'h13572468;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_state", dbg_state, ARB_IDLE);
      check("rst_mem_req", bus.mem_req, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_if_rdata", bus.if_rdata, 32'h0);
      check("rst_d_rdata", bus.d_rdata, 32'h0);
      check("rst_valids", {bus.if_valid, bus.d_valid}, 2'b00);
      check("rst_starve_cnt", dbg_starve_cnt, 3'd0);
      #1 rst = 1'b1;

      // Test 1: async reset in the middle of a data access
      @(negedge clk);
      #1;
      mem_lat = 20;
      push_mem(1'b0, 32'h100, 32'h0, 3'd0);
      bus.d_addr = 32'h100;
      bus.d_we   = 1'b0;
      bus.d_req  = 1'b1;
      wait_mem_req(1'b1, "t1_grant");
      @(negedge clk);
      #1;
      check("t1_busy_d", dbg_state, ARB_BUSY_D);
      check("t1_d_stall", bus.d_stall, 1'b1);
      rst = 1'b0;
      bus.d_req = 1'b0;
      #1;
      check("t1_async_mem_req", bus.mem_req, 1'b0);
      check("t1_async_state", dbg_state, ARB_IDLE);
      check("t1_async_outs", {bus.mem_we, bus.mem_addr, bus.d_rdata}, 65'h0);
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1;
      check("t1_idle_after", dbg_state, ARB_IDLE);
      check("t1_mem_req_after", bus.mem_req, 1'b0);

      // Test 2: lone fetch, memory answers one cycle after mem_req
      mem_lat = 1;
      push_mem(1'b0, 32'h40, 32'h0, 3'd0);
      exp_if_q.push_back(32'h8C010004);
      bus.if_addr = 32'h40;
      bus.if_req  = 1'b1;
      @(negedge clk);
      #1;
      check("t2_c1_mem_req", bus.mem_req, 1'b1);
      check("t2_c1_if_stall", bus.if_stall, 1'b1);
      @(negedge clk);
      #1;
      check("t2_c2_if_valid", bus.if_valid, 1'b0);
      @(negedge clk);
      #1;
      check("t2_c3_if_valid", bus.if_valid, 1'b1);
      check("t2_c3_if_stall", bus.if_stall, 1'b0);
      bus.if_req = 1'b0;

      // Test 3: fetch and load in the same cycle, data wins
      @(negedge clk);
      #1;
      mem_lat = 0;
      push_mem(1'b0, 32'h100, 32'h0, 3'd1);
      push_mem(1'b0, 32'h80, 32'h0, 3'd0);
      exp_d_q.push_back(32'hA5A50100);
      exp_if_q.push_back(32'h20020080);
      base_d = d_seen;
      base_i = if_seen;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h100;
      bus.if_addr = 32'h80;
      bus.d_req   = 1'b1;
      bus.if_req  = 1'b1;
      n = 0;
      while (d_seen == base_d && n < 30) begin
         @(negedge clk);
         #1;
         n++;
         check("t3_if_stall_during_d", bus.if_stall, 1'b1);
      end
      if (d_seen == base_d) fail_now("t3_d_done");
      bus.d_req = 1'b0;
      n = 0;
      while (if_seen == base_i && n < 30) begin
         @(negedge clk);
         #1;
         n++;
         if (!bus.if_valid) check("t3_if_stall_wait", bus.if_stall, 1'b1);
      end
      if (if_seen == base_i) fail_now("t3_i_done");
      bus.if_req = 1'b0;

      // Test 4: starvation guard, both held -> D,D,D,D,I,D
      @(negedge clk);
      #1;
      mem_lat = 0;
      push_mem(1'b0, 32'h300, 32'h0, 3'd1);
      push_mem(1'b0, 32'h300, 32'h0, 3'd2);
      push_mem(1'b0, 32'h300, 32'h0, 3'd3);
      push_mem(1'b0, 32'h300, 32'h0, 3'd4);
      push_mem(1'b0, 32'h80, 32'h0, 3'd0);
      push_mem(1'b0, 32'h300, 32'h0, 3'd1);
      repeat (5) exp_d_q.push_back(32'h13572468);
      exp_if_q.push_back(32'h20020080);
      base_d = d_seen;
      base_i = if_seen;
      bus.d_addr  = 32'h300;
      bus.if_addr = 32'h80;
      bus.d_req   = 1'b1;
      bus.if_req  = 1'b1;
      n = 0;
      while (d_seen < base_d + 5 && n < 80) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (d_seen < base_d + 5) fail_now("t4_d_grants");
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
      check("t4_if_count", if_seen - base_i, 1);
      @(negedge clk);
      #1;
      check("t4_cnt_clear_no_req", dbg_starve_cnt, 3'd0);

      // Test 5a: flush in IDLE blocks the fetch grant for that cycle only
      mem_lat = 5;
      bus.if_addr  = 32'h44;
      bus.if_req   = 1'b1;
      bus.if_flush = 1'b1;
      @(negedge clk);
      #1;
      check("t5_idle_flush_block", bus.mem_req, 1'b0);
      push_mem(1'b0, 32'h44, 32'h0, 3'd0);
      bus.if_flush = 1'b0;
      // Test 5b: flush while the fetch is outstanding
      wait_mem_req(1'b1, "t5_grant");
      check("t5_busy_i", dbg_state, ARB_BUSY_I);
      bus.if_flush = 1'b1;
      bus.if_req   = 1'b0;
      @(negedge clk);
      #1;
      bus.if_flush = 1'b0;
      base_i = if_seen;
      wait_mem_req(1'b0, "t5_complete");
      repeat (2) @(negedge clk);
      #1;
      check("t5_no_if_valid", if_seen - base_i, 0);
      check("t5_if_rdata_kept", bus.if_rdata, 32'h20020080);
      mem_lat = 1;
      push_mem(1'b0, 32'h48, 32'h0, 3'd0);
      exp_if_q.push_back(32'h00430820);
      run_i(32'h48, "t5_next_fetch");

      // Test 6: store keeps d_rdata, then read it back
      @(negedge clk);
      #1;
      mem_lat = 2;
      push_mem(1'b1, 32'h200, 32'hDEADBEEF, 3'd0);
      exp_d_q.push_back(32'h13572468);
      run_d(1'b1, 32'h200, 32'hDEADBEEF, "t6_store");
      check("t6_d_rdata_held", bus.d_rdata, 32'h13572468);
      @(negedge clk);
      #1;
      check("t6_mem_we_cleared", bus.mem_we, 1'b0);
      push_mem(1'b0, 32'h200, 32'h0, 3'd0);
      exp_d_q.push_back(32'hDEADBEEF);
      run_d(1'b0, 32'h200, 32'h0, "t6_load_back");

      // Drain and final bookkeeping
      repeat (3) @(negedge clk);
      #1;
      check("left_exp_if", exp_if_q.size(), 0);
      check("left_exp_d", exp_d_q.size(), 0);
      check("left_exp_mem", exp_mem_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mem_port_arbiter
